inst_bundle_loader: RTL and testbench



---
 rtl/inst_bundle_loader.sv | 123 ++++++++++++
 tb/tb_inst_bundle_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_bundle_loader.sv
// Streams 32-bit slot words in over valid/ready, packs NSLOT of them into one
// VLIW bundle and writes each bundle to instruction memory at consecutive indices.
module inst_bundle_loader #(
    parameter int NSLOT     = 10,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_bundles,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_data,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [NSLOT*WORD_W-1:0] wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int SLOT_W = $clog2(NSLOT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t             state_r;
    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [CNT_W-1:0]   bundle_cnt_r;
    logic [CNT_W-1:0]   num_r;
    logic               last_slot_s;
    logic               last_bundle_s;

    assign last_slot_s   = (slot_cnt_r == SLOT_W'(NSLOT - 1));
    assign last_bundle_s = (bundle_cnt_r == (num_r - CNT_W'(1)));

    // Loader FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            slot_cnt_r   <= {SLOT_W{1'b0}};
            bundle_cnt_r <= {CNT_W{1'b0}};
            num_r        <= {CNT_W{1'b0}};
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= {ADDR_W{1'b0}};
            wr_data      <= {(NSLOT*WORD_W){1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_bundles != {CNT_W{1'b0}}) begin
                            wr_addr      <= base_addr;
                            num_r        <= num_bundles;
                            bundle_cnt_r <= {CNT_W{1'b0}};
                            slot_cnt_r   <= {SLOT_W{1'b0}};
                            in_ready     <= 1'b1;
                            state_r      <= COLLECT;
                        end else begin
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end
                    end
                end
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        // word k lands in slot NSLOT-1-k so word 0 is the MSB slot
                        for (int i = 0; i < NSLOT; i++) begin
                            if (slot_cnt_r == SLOT_W'(i)) begin
                                wr_data[(NSLOT-i)*WORD_W-1 -: WORD_W] <= in_data;
                            end
                        end
                        if (last_slot_s) begin
                            in_ready <= 1'b0;
                            wr_en    <= 1'b1;
                            state_r  <= WRITE;
                        end else begin
                            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en        <= 1'b0;
                        wr_addr      <= wr_addr + ADDR_W'(ADDR_STEP);
                        bundle_cnt_r <= bundle_cnt_r + CNT_W'(1);
                        if (last_bundle_s) begin
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end else begin
                            slot_cnt_r <= {SLOT_W{1'b0}};
                            in_ready   <= 1'b1;
                            state_r    <= COLLECT;
                        end
                    end
                end
                FINISH: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_bundle_loader.sv
// Randomized bench for inst_bundle_loader: expected bundles and addresses come
// from a queue-based model of the word stream, checked at each write handshake.
module tb_inst_bundle_loader;

    localparam int NSLOT     = 10;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int ADDR_STEP = 4;
    localparam int CNT_W     = 16;
    localparam int BW        = NSLOT * WORD_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_bundles;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [BW-1:0]     wr_data;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_bad    = 0;

    inst_bundle_loader #(
        .NSLOT(NSLOT), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .ADDR_STEP(ADDR_STEP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_bundles(num_bundles), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // vmode: 0 valid always, 1 every other cycle, 2 random; stall: wr_ready low cycles per write
    task automatic run_load(input logic [ADDR_W-1:0] base, input int nb, input int vmode,
                            input int stall, input bit seq_data, input int restart_at);
        logic [WORD_W-1:0] words[$];
        logic [BW-1:0]     exp_data[$];
        logic [ADDR_W-1:0] exp_addr[$];
        logic [BW-1:0]     bundle;
        logic [ADDR_W-1:0] prev_addr;
        logic [BW-1:0]     prev_data;
        bit                prev_hold;
        int total, widx, wcnt, stall_ctr, cyc, done_cyc;

        total = nb * NSLOT;
        for (int i = 0; i < total; i++)
            words.push_back(seq_data ? (32'h1000_0000 + WORD_W'(i)) : WORD_W'($urandom()));
        for (int b = 0; b < nb; b++) begin
            bundle = '0;
            for (int s = 0; s < NSLOT; s++)
                bundle = {bundle[BW-WORD_W-1:0], words[b*NSLOT+s]};
            exp_data.push_back(bundle);
            exp_addr.push_back(base + ADDR_W'(ADDR_STEP * b));
        end

        start       = 1'b1;
        base_addr   = base;
        num_bundles = CNT_W'(nb);
        @(posedge clk); #1;
        start = 1'b0;

        widx = 0; wcnt = 0; stall_ctr = 0; cyc = 1; done_cyc = -1; prev_hold = 1'b0;
        prev_addr = '0; prev_data = '0;
        while (done_cyc < 0 && cyc < 3000) begin
            if (cyc == restart_at) begin
                start = 1'b1; base_addr = 32'd100; num_bundles = 16'd5;
            end else begin
                start = 1'b0;
            end
            check_eq("busy_during_load", busy, 1'b1);
            if (done) done_cyc = cyc;
            if (prev_hold) begin
                check_eq("wr_addr_stable", wr_addr, prev_addr);
                check_eq("wr_data_stable", wr_data, prev_data);
            end
            in_valid = (widx < total) &&
                       (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                        (vmode == 2 && $urandom_range(0, 1) == 1));
            in_data = in_valid ? words[widx] : WORD_W'($urandom());
            if (stall == 0) begin
                wr_ready = 1'b1;
            end else if (wr_en) begin
                wr_ready  = (stall_ctr == stall);
                stall_ctr = wr_ready ? 0 : stall_ctr + 1;
            end else begin
                wr_ready = 1'($urandom_range(0, 1));
            end
            if (wr_en && wr_ready) begin
                if (wcnt < nb) begin
                    check_eq("write_addr", wr_addr, exp_addr[wcnt]);
                    check_eq("write_data", wr_data, exp_data[wcnt]);
                end else begin
                    check_eq("extra_write", 1'b1, 1'b0);
                end
                wcnt++;
            end
            prev_hold = wr_en && !wr_ready;
            prev_addr = wr_addr;
            prev_data = wr_data;
            if (in_valid && in_ready) widx++;
            @(posedge clk); #1;
            cyc++;
        end

        start    = 1'b0;
        in_valid = 1'b0;
        check_eq("done_seen", done_cyc > 0, 1'b1);
        if (vmode == 0 && stall == 0)
            check_eq("done_latency", 32'(done_cyc), 32'(nb * (NSLOT + 1) + 1));
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("busy_after_done", busy, 1'b0);
        check_eq("wr_en_after_done", wr_en, 1'b0);
        check_eq("in_ready_after_done", in_ready, 1'b0);
        check_eq("words_consumed", 32'(widx), 32'(total));
        check_eq("write_count", 32'(wcnt), 32'(nb));
        if (nb > 0) check_eq("wr_data_held", wr_data, exp_data[nb-1]);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_wr_en"}, wr_en, 1'b0);
        check_eq({tag, "_wr_addr"}, wr_addr, '0);
        check_eq({tag, "_wr_data"}, wr_data, '0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
    endtask

    // Start one bundle, feed five words, then hit reset mid-collection
    task automatic abort_load();
        int accepted;
        int guard;
        start = 1'b1; base_addr = '0; num_bundles = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        accepted = 0; guard = 0;
        while (accepted < 5 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = WORD_W'($urandom());
            wr_ready = 1'b1;
            check_eq("abort_no_write", wr_en, 1'b0);
            if (in_ready) accepted++;
            @(posedge clk); #1;
            guard++;
        end
        check_eq("abort_feed_timeout", 32'(accepted), 32'd5);
        reset    = 1'b1;
        in_valid = 1'b0;
        #2;
        check_reset_values("abort_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("abort_after");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; num_bundles = '0;
        in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_load(32'd0, 3, 0, 0, 1'b1, -1);
        run_load(32'd0, 3, 1, 3, 1'b1, -1);
        run_load(32'd0, 0, 0, 0, 1'b0, -1);
        run_load(32'd200, 2, 0, 0, 1'b0, 3);
        abort_load();
        run_load(32'd16, 1, 2, 1, 1'b0, -1);
        run_load(32'hFFFF_FFFC, 2, 2, 1, 1'b0, -1);
        for (int k = 0; k < 4; k++)
            run_load(ADDR_W'($urandom()), $urandom_range(1, 4), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
